// File: rtl/iq_phase_discriminator_if.sv
// rtl/iq_phase_discriminator_if.sv - sample in / phase-freq-mag out bundle for the IQ phase discriminator
interface iq_phase_discriminator_if #(
    parameter int DW = 10,
    parameter int PW = 32
);
    logic                 en;
    logic signed [DW-1:0] i_in;
    logic signed [DW-1:0] q_in;
    logic                 out_valid;
    logic [PW-1:0]        phase;
    logic signed [PW-1:0] freq;
    logic [DW+1:0]        mag;

    modport master (
        output en, i_in, q_in,
        input  out_valid, phase, freq, mag
    );

    modport slave (
        input  en, i_in, q_in,
        output out_valid, phase, freq, mag
    );
endinterface

// File: rtl/iq_phase_discriminator.sv
// rtl/iq_phase_discriminator.sv - pipelined vectoring CORDIC recovering phase, phase step and magnitude from I/Q
module iq_phase_discriminator #(
    parameter int DW   = 10,
    parameter int PW   = 32,
    parameter int ITER = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    iq_phase_discriminator_if.slave  bus
);
    localparam int XW = DW + 3;

    function automatic logic [PW-1:0] atan_word(input int s);
        real r;
        r = $atan(1.0 / (2.0 ** s)) / (2.0 * 3.14159265358979323846) * (2.0 ** PW);
        return PW'(longint'(r));
    endfunction

    logic [PW-1:0] w_atan [0:ITER-1];

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        assign w_atan[g] = atan_word(g);
    end

    logic                 r_cap_v;
    logic signed [DW-1:0] r_cap_i;
    logic signed [DW-1:0] r_cap_q;

    logic                 r_v [0:ITER];
    logic signed [XW-1:0] r_x [0:ITER];
    logic signed [XW-1:0] r_y [0:ITER];
    logic [PW-1:0]        r_z [0:ITER];

    logic                 r_first;
    logic [PW-1:0]        r_prev_z;
    logic                 r_out_valid;
    logic [PW-1:0]        r_phase;
    logic [PW-1:0]        r_freq;
    logic [DW+1:0]        r_mag;

    // Three extra bits let -(-2^(DW-1)) and the ~1.65x CORDIC gain fit without wrapping.
    logic signed [XW-1:0] w_i_ext;
    logic signed [XW-1:0] w_q_ext;

    assign w_i_ext = {{(XW-DW){r_cap_i[DW-1]}}, r_cap_i};
    assign w_q_ext = {{(XW-DW){r_cap_q[DW-1]}}, r_cap_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_v     <= 1'b0;
            r_cap_i     <= '0;
            r_cap_q     <= '0;
            for (int k = 0; k <= ITER; k++) begin
                r_v[k] <= 1'b0;
                r_x[k] <= '0;
                r_y[k] <= '0;
                r_z[k] <= '0;
            end
            r_first     <= 1'b1;
            r_prev_z    <= '0;
            r_out_valid <= 1'b0;
            r_phase     <= '0;
            r_freq      <= '0;
            r_mag       <= '0;
        end else begin
            r_cap_v <= bus.en;
            r_cap_i <= bus.i_in;
            r_cap_q <= bus.q_in;

            // Fold the left half-plane onto the right so the micro-rotations only cover +-99.9 deg.
            r_v[0] <= r_cap_v;
            if (r_cap_i[DW-1]) begin
                r_x[0] <= -w_i_ext;
                r_y[0] <= -w_q_ext;
                r_z[0] <= {1'b1, {(PW-1){1'b0}}};
            end else begin
                r_x[0] <= w_i_ext;
                r_y[0] <= w_q_ext;
                r_z[0] <= '0;
            end

            for (int k = 1; k <= ITER; k++) begin
                r_v[k] <= r_v[k-1];
                if (!r_y[k-1][XW-1]) begin
                    r_x[k] <= r_x[k-1] + (r_y[k-1] >>> (k-1));
                    r_y[k] <= r_y[k-1] - (r_x[k-1] >>> (k-1));
                    r_z[k] <= r_z[k-1] + w_atan[k-1];
                end else begin
                    r_x[k] <= r_x[k-1] - (r_y[k-1] >>> (k-1));
                    r_y[k] <= r_y[k-1] + (r_x[k-1] >>> (k-1));
                    r_z[k] <= r_z[k-1] - w_atan[k-1];
                end
            end

            // Modular subtraction makes the 360->0 and 180 deg crossings come out as small steps.
            r_out_valid <= r_v[ITER];
            if (r_v[ITER]) begin
                r_phase  <= r_z[ITER];
                r_mag    <= r_x[ITER][DW+1:0];
                r_freq   <= r_first ? '0 : (r_z[ITER] - r_prev_z);
                r_prev_z <= r_z[ITER];
                r_first  <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.phase     = r_phase;
    assign bus.freq      = r_freq;
    assign bus.mag       = r_mag;
endmodule

// File: tb/tb_iq_phase_discriminator.sv
// tb/tb_iq_phase_discriminator.sv - randomized and directed checks of iq_phase_discriminator against an atan2 model
module tb_iq_phase_discriminator;
    localparam int  DW   = 10;
    localparam int  PW   = 32;
    localparam int  ITER = 16;
    localparam int  LAT  = ITER + 2;
    localparam real PI   = 3.14159265358979323846;
    localparam longint PH_TOL = 64'd8388608;
    localparam int  MAG_TOL = 10;

    logic clk = 1'b0;
    logic rst;

    iq_phase_discriminator_if #(.DW(DW), .PW(PW)) bus ();

    iq_phase_discriminator #(.DW(DW), .PW(PW), .ITER(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
        longint d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_checks++;
        if (d > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (tolerance %0d) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    typedef struct {
        int          cap;
        logic [31:0] ph;
        bit          amp_ok;
        int          mag_exp;
        int          mag_tol;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [31:0] ideal_phase(input int i, input int q);
        real a;
        real c;
        a = $atan2(real'(q), real'(i));
        c = a / (2.0 * PI) * 4294967296.0;
        if (c < 0.0) c = c + 4294967296.0;
        return 32'(longint'(c));
    endfunction

    function automatic int ideal_mag(input int i, input int q);
        return int'(1.6468 * $sqrt(real'(i * i + q * q)));
    endfunction

    task automatic drive(input bit e, input int i, input int q, input int mag_tol);
        exp_t x;
        @(negedge clk);
        bus.en   = e;
        bus.i_in = DW'(i);
        bus.q_in = DW'(q);
        if (e) begin
            x.cap     = cyc + 1;
            x.ph      = ideal_phase(i, q);
            x.amp_ok  = (i * i + q * q) >= 65536;
            x.mag_exp = ideal_mag(i, q);
            x.mag_tol = mag_tol;
            exp_q.push_back(x);
        end
    endtask

    task automatic drive_tone(input int n);
        real a;
        a = 2.0 * PI * real'(n) / 256.0;
        drive(1'b1, int'(500.0 * $cos(a)), int'(500.0 * $sin(a)), -1);
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    int          n_valid = 0;
    bit          first   = 1'b1;
    bit          prev_ok = 1'b0;
    logic [31:0] prev_ph = '0;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] d;
        if (rst) begin
            first   = 1'b1;
            prev_ok = 1'b0;
        end else if (bus.out_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check_val("spurious_valid", 1, 0, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("latency", cyc - e.cap, LAT, 0);
                if (e.amp_ok) begin
                    d = bus.phase - e.ph;
                    check_val("phase_err", longint'($signed(d)), 0, PH_TOL);
                end
                if (e.mag_tol >= 0)
                    check_val("mag", longint'(bus.mag), e.mag_exp, e.mag_tol);
                if (first) begin
                    check_val("freq_first", longint'(bus.freq), 0, 0);
                end else if (e.amp_ok && prev_ok) begin
                    d = 32'(bus.freq) - (e.ph - prev_ph);
                    check_val("freq_err", longint'($signed(d)), 0, PH_TOL);
                end
                first   = 1'b0;
                prev_ok = e.amp_ok;
                prev_ph = e.ph;
            end
        end
    end

    initial begin
        int n;
        int base;
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.i_in = '0;
        bus.q_in = '0;
        repeat (3) @(negedge clk);
        check_val("rst_valid", longint'(bus.out_valid), 0, 0);
        check_val("rst_phase", longint'(bus.phase), 0, 0);
        check_val("rst_freq",  longint'(bus.freq), 0, 0);
        check_val("rst_mag",   longint'(bus.mag), 0, 0);
        rst = 1'b0;

        drive(1'b1,  511,    0, MAG_TOL);
        drive(1'b0,    0,    0, -1);
        drive(1'b1,    0,  511, MAG_TOL);
        drive(1'b1, -511,    0, MAG_TOL);
        drive(1'b0,  100,  -50, -1);
        drive(1'b1,    0, -511, MAG_TOL);
        drive(1'b1, -512, -512, MAG_TOL);
        drive(1'b1,    0,    0, 0);
        repeat (LAT + 4) drive(1'b0, 0, 0, -1);

        for (n = 0; n < 300; n++) drive_tone(n);

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check_val("arst_valid", longint'(bus.out_valid), 0, 0);
        check_val("arst_phase", longint'(bus.phase), 0, 0);
        check_val("arst_freq",  longint'(bus.freq), 0, 0);
        check_val("arst_mag",   longint'(bus.mag), 0, 0);
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        base = n_valid;
        repeat (30) drive(1'b0, rnd_s(), rnd_s(), -1);
        check_val("idle_after_reset", n_valid - base, 0, 0);

        n = 17;
        for (int g = 0; g < 60; g++) begin
            drive_tone(n);
            n--;
            drive(1'b0, rnd_s(), rnd_s(), -1);
            drive(1'b0, rnd_s(), rnd_s(), -1);
            drive_tone(n);
            n--;
        end
        repeat (LAT + 4) drive(1'b0, 0, 0, -1);

        base = n_valid;
        for (int k = 0; k < 1000; k++) drive(1'b1, rnd_s(), rnd_s(), -1);
        repeat (LAT + 10) drive(1'b0, 0, 0, -1);
        check_val("burst_count", n_valid - base, 1000, 0);
        check_val("drain", exp_q.size(), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
